// File: rtl/csr_access_unit.sv
// Zicsr sequencer: reads the addressed CSR, screens the file's illegal flags,
// issues the write with the latched mode, and returns the old value to writeback.
module csr_access_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            clk_en_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [1:0]      req_op_i,
    input  logic [11:0]     req_addr_i,
    input  logic [XLEN-1:0] req_src_i,
    input  logic            req_src_zero_i,
    input  logic [4:0]      req_rd_i,
    output logic            csr_rd_o,
    output logic [11:0]     csr_rd_addr_o,
    input  logic [XLEN-1:0] csr_rd_data_i,
    input  logic            csr_rd_illegal_rd_i,
    input  logic            csr_rd_illegal_wr_i,
    output logic            csr_wr_o,
    output logic [1:0]      csr_wr_mode_o,
    output logic [11:0]     csr_wr_addr_o,
    output logic [XLEN-1:0] csr_wr_data_o,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [4:0]      rsp_rd_o,
    output logic [XLEN-1:0] rsp_data_o,
    output logic            rsp_wen_o,
    output logic            rsp_illegal_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CHECK,
        S_WRITE,
        S_RESP
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [11:0]     addr_q, addr_d;
    logic [XLEN-1:0] src_q, src_d;
    logic            src_zero_q, src_zero_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            illegal_q, illegal_d;
    logic            wen_q, wen_d;

    logic rd_nz;
    logic rd_need;
    logic wr_need;
    logic illegal_now;

    // Access classification; only meaningful while in CHECK.
    always_comb begin
        rd_nz       = (rd_q != 5'd0);
        rd_need     = (op_q != 2'b01) | rd_nz;
        wr_need     = (op_q == 2'b01) | ~src_zero_q;
        illegal_now = (op_q == 2'b00)
                    | (rd_need & csr_rd_illegal_rd_i)
                    | (wr_need & csr_rd_illegal_wr_i);
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        src_d      = src_q;
        src_zero_d = src_zero_q;
        rd_d       = rd_q;
        data_d     = data_q;
        illegal_d  = illegal_q;
        wen_d      = wen_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    op_d       = req_op_i;
                    addr_d     = req_addr_i;
                    src_d      = req_src_i;
                    src_zero_d = req_src_zero_i;
                    rd_d       = req_rd_i;
                    state_d    = S_READ;
                end
            end
            S_READ: state_d = S_CHECK;
            S_CHECK: begin
                data_d    = csr_rd_data_i;
                illegal_d = illegal_now;
                wen_d     = rd_need & rd_nz & ~illegal_now;
                state_d   = (wr_need & ~illegal_now) ? S_WRITE : S_RESP;
            end
            S_WRITE: state_d = S_RESP;
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            addr_q     <= '0;
            src_q      <= '0;
            src_zero_q <= 1'b0;
            rd_q       <= '0;
            data_q     <= '0;
            illegal_q  <= 1'b0;
            wen_q      <= 1'b0;
        end else if (clk_en_i) begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            src_q      <= src_d;
            src_zero_q <= src_zero_d;
            rd_q       <= rd_d;
            data_q     <= data_d;
            illegal_q  <= illegal_d;
            wen_q      <= wen_d;
        end
    end

    // Address stays on the read port through WRITE so the file merges the right CSR.
    always_comb begin
        req_ready_o   = (state_q == S_IDLE);
        csr_rd_o      = (state_q == S_READ);
        csr_rd_addr_o = addr_q;
        csr_wr_o      = (state_q == S_WRITE);
        csr_wr_mode_o = op_q;
        csr_wr_addr_o = addr_q;
        csr_wr_data_o = src_q;
        rsp_valid_o   = (state_q == S_RESP);
        rsp_rd_o      = rd_q;
        rsp_data_o    = data_q;
        rsp_wen_o     = (state_q == S_RESP) & wen_q;
        rsp_illegal_o = (state_q == S_RESP) & illegal_q;
    end

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed bench for csr_access_unit with a registered CSR-file read model
// and a counter of enabled write strobes.
module tb_csr_access_unit;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        clk_en_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [1:0]  req_op_i;
    logic [11:0] req_addr_i;
    logic [31:0] req_src_i;
    logic        req_src_zero_i;
    logic [4:0]  req_rd_i;
    logic        csr_rd_o;
    logic [11:0] csr_rd_addr_o;
    logic [31:0] csr_rd_data_i;
    logic        csr_rd_illegal_rd_i;
    logic        csr_rd_illegal_wr_i;
    logic        csr_wr_o;
    logic [1:0]  csr_wr_mode_o;
    logic [11:0] csr_wr_addr_o;
    logic [31:0] csr_wr_data_o;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [4:0]  rsp_rd_o;
    logic [31:0] rsp_data_o;
    logic        rsp_wen_o;
    logic        rsp_illegal_o;

    csr_access_unit #(.XLEN(32)) dut (
        .clk_i               (clk_i),
        .reset_i             (reset_i),
        .clk_en_i            (clk_en_i),
        .req_valid_i         (req_valid_i),
        .req_ready_o         (req_ready_o),
        .req_op_i            (req_op_i),
        .req_addr_i          (req_addr_i),
        .req_src_i           (req_src_i),
        .req_src_zero_i      (req_src_zero_i),
        .req_rd_i            (req_rd_i),
        .csr_rd_o            (csr_rd_o),
        .csr_rd_addr_o       (csr_rd_addr_o),
        .csr_rd_data_i       (csr_rd_data_i),
        .csr_rd_illegal_rd_i (csr_rd_illegal_rd_i),
        .csr_rd_illegal_wr_i (csr_rd_illegal_wr_i),
        .csr_wr_o            (csr_wr_o),
        .csr_wr_mode_o       (csr_wr_mode_o),
        .csr_wr_addr_o       (csr_wr_addr_o),
        .csr_wr_data_o       (csr_wr_data_o),
        .rsp_valid_o         (rsp_valid_o),
        .rsp_ready_i         (rsp_ready_i),
        .rsp_rd_o            (rsp_rd_o),
        .rsp_data_o          (rsp_data_o),
        .rsp_wen_o           (rsp_wen_o),
        .rsp_illegal_o       (rsp_illegal_o)
    );

    always #5 clk_i = ~clk_i;

    // CSR file model: value and flags the file will return for the next read.
    logic [31:0] file_val;
    logic        file_ill_rd;
    logic        file_ill_wr;
    int          wr_count = 0;

    always @(posedge clk_i) begin
        if (clk_en_i && csr_rd_o) begin
            csr_rd_data_i       <= file_val;
            csr_rd_illegal_rd_i <= file_ill_rd;
            csr_rd_illegal_wr_i <= file_ill_wr;
        end
        if (clk_en_i && !reset_i && csr_wr_o) begin
            wr_count <= wr_count + 1;
        end
    end

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_txn(input string name, input logic [1:0] op, input logic [11:0] addr,
                           input logic [31:0] src, input logic src_zero, input logic [4:0] rd,
                           input logic [31:0] old, input logic ill_rd, input logic ill_wr,
                           input logic exp_write, input logic exp_illegal, input logic exp_wen);
        int wc0;
        wc0            = wr_count;
        req_op_i       = op;
        req_addr_i     = addr;
        req_src_i      = src;
        req_src_zero_i = src_zero;
        req_rd_i       = rd;
        file_val       = old;
        file_ill_rd    = ill_rd;
        file_ill_wr    = ill_wr;
        req_valid_i    = 1'b1;
        chk({name, ".ready_T"}, req_ready_o, 1);
        tick();
        req_valid_i = 1'b0;
        chk({name, ".rd_T1"}, csr_rd_o, 1);
        chk({name, ".rdaddr_T1"}, csr_rd_addr_o, addr);
        chk({name, ".busy_T1"}, req_ready_o, 0);
        tick();
        chk({name, ".strobes_T2"}, {csr_rd_o, csr_wr_o, rsp_valid_o}, 0);
        tick();
        if (exp_write) begin
            chk({name, ".wr_T3"}, {csr_wr_o, rsp_valid_o}, 2'b10);
            chk({name, ".wrmode"}, csr_wr_mode_o, op);
            chk({name, ".wraddr"}, csr_wr_addr_o, addr);
            chk({name, ".wrdata"}, csr_wr_data_o, src);
            tick();
        end
        chk({name, ".rsp_valid"}, {csr_wr_o, rsp_valid_o}, 2'b01);
        chk({name, ".rsp_rd"}, rsp_rd_o, rd);
        chk({name, ".rsp_data"}, rsp_data_o, old);
        chk({name, ".rsp_flags"}, {rsp_wen_o, rsp_illegal_o}, {exp_wen, exp_illegal});
        chk({name, ".rdaddr_resp"}, csr_rd_addr_o, addr);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        chk({name, ".idle_after"}, {req_ready_o, rsp_valid_o}, 2'b10);
        chk({name, ".wr_count"}, wr_count - wc0, exp_write ? 1 : 0);
    endtask

    initial begin
        int wc0;
        logic [31:0] held;
        reset_i        = 1'b1;
        clk_en_i       = 1'b1;
        req_valid_i    = 1'b0;
        req_op_i       = 2'b00;
        req_addr_i     = '0;
        req_src_i      = '0;
        req_src_zero_i = 1'b0;
        req_rd_i       = '0;
        rsp_ready_i    = 1'b0;
        file_val       = '0;
        file_ill_rd    = 1'b0;
        file_ill_wr    = 1'b0;
        tick();
        tick();
        reset_i = 1'b0;
        tick();
        chk("reset.ready", req_ready_o, 1);
        chk("reset.strobes", {csr_rd_o, csr_wr_o, rsp_valid_o, rsp_wen_o, rsp_illegal_o}, 0);
        chk("reset.fields", {rsp_rd_o, rsp_data_o}, 0);

        run_txn("rw340", 2'b01, 12'h340, 32'hDEADBEEF, 1'b0, 5'd5, 32'h0, 1'b0, 1'b0, 1, 0, 1);
        run_txn("rsf14", 2'b10, 12'hF14, 32'h0, 1'b1, 5'd7, 32'h0, 1'b0, 1'b0, 0, 0, 1);
        run_txn("rwill", 2'b01, 12'hF11, 32'h1234, 1'b0, 5'd0, 32'hA5A5A5A5, 1'b0, 1'b1, 0, 1, 0);
        run_txn("op00", 2'b00, 12'h300, 32'h5, 1'b0, 5'd3, 32'h11, 1'b0, 1'b0, 0, 1, 0);
        run_txn("rc8", 2'b11, 12'h300, 32'h8, 1'b0, 5'd0, 32'h1888, 1'b0, 1'b0, 1, 0, 0);
        run_txn("rsillrd", 2'b10, 12'h7C0, 32'h3, 1'b0, 5'd9, 32'h42, 1'b1, 1'b0, 0, 1, 0);
        // rd=0 RW ignores a read-illegal flag since no read is architecturally needed
        run_txn("rwrd0", 2'b01, 12'h341, 32'hCAFE0001, 1'b0, 5'd0, 32'h77, 1'b1, 1'b0, 1, 0, 0);

        // Clock-enable stall during WRITE plus backpressured response
        wc0            = wr_count;
        req_op_i       = 2'b01;
        req_addr_i     = 12'h305;
        req_src_i      = 32'h80000000;
        req_src_zero_i = 1'b0;
        req_rd_i       = 5'd12;
        file_val       = 32'h00000100;
        file_ill_rd    = 1'b0;
        file_ill_wr    = 1'b0;
        req_valid_i    = 1'b1;
        tick();
        req_valid_i = 1'b0;
        tick();
        tick();
        chk("stall.wr_enter", csr_wr_o, 1);
        clk_en_i = 1'b0;
        tick();
        chk("stall.wr_held1", {csr_wr_o, rsp_valid_o}, 2'b10);
        tick();
        chk("stall.wr_held2", {csr_wr_o, csr_wr_data_o}, {1'b1, 32'h80000000});
        clk_en_i = 1'b1;
        tick();
        chk("stall.single_wr", wr_count - wc0, 1);
        req_valid_i    = 1'b1;
        req_op_i       = 2'b10;
        req_addr_i     = 12'hF14;
        req_src_i      = 32'h0;
        req_src_zero_i = 1'b1;
        req_rd_i       = 5'd4;
        held           = 32'h00000100;
        for (int i = 0; i < 5; i++) begin
            chk("bp.valid", {rsp_valid_o, req_ready_o, csr_wr_o}, 3'b100);
            chk("bp.stable", {rsp_rd_o, rsp_wen_o, rsp_illegal_o, rsp_data_o}, {5'd12, 1'b1, 1'b0, held});
            tick();
        end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        chk("bp.idle_after_hs", {req_ready_o, csr_rd_o, rsp_valid_o}, 3'b100);
        file_val = 32'h00000001;
        tick();
        req_valid_i = 1'b0;
        chk("bp.next_accept", {csr_rd_o, csr_rd_addr_o}, {1'b1, 12'hF14});
        tick();
        tick();
        chk("bp.next_rsp", {rsp_valid_o, rsp_rd_o, rsp_data_o}, {1'b1, 5'd4, 32'h1});
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        chk("bp.wr_total", wr_count - wc0, 1);

        // Reset during CHECK of a CSRRW drops the transaction
        wc0            = wr_count;
        req_op_i       = 2'b01;
        req_addr_i     = 12'h340;
        req_src_i      = 32'h13572468;
        req_src_zero_i = 1'b0;
        req_rd_i       = 5'd6;
        req_valid_i    = 1'b1;
        tick();
        req_valid_i = 1'b0;
        tick();
        chk("rst.in_check", {csr_rd_o, csr_wr_o, rsp_valid_o, req_ready_o}, 0);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        chk("rst.idle", {req_ready_o, csr_rd_o}, 2'b10);
        for (int i = 0; i < 4; i++) begin
            chk("rst.quiet", {csr_wr_o, rsp_valid_o, req_ready_o}, 3'b001);
            tick();
        end
        chk("rst.no_wr", wr_count - wc0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/csr_access_unit.md
# csr_access_unit

Sequencer for Zicsr instructions (CSRRW/CSRRS/CSRRC and immediate forms) between the execute stage and the CSR register file. Accepts one decoded CSR request, reads the addressed CSR, checks the file's illegal-read/illegal-write flags, and issues the write with the correct mode. Returns the old CSR value to writeback over a valid/ready handshake. The unit drives the CSR file's read/write port; the CSR file computes the set/clear merge.

## Interface
- XLEN, 32, data width; matches `RV_XLEN`.

- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- clk_en_i  in  1  global clock enable; when low, all state and captures hold
- req_valid_i  in  1  CSR request valid
- req_ready_o  out  1  unit idle and able to accept
- req_op_i  in  2  01 RW, 10 RS, 11 RC, 00 reserved (illegal)
- req_addr_i  in  12  CSR address
- req_src_i  in  XLEN  rs1 value or zero-extended zimm
- req_src_zero_i  in  1  rs1 index / zimm field is zero
- req_rd_i  in  5  destination register index
- csr_rd_o  out  1  CSR read strobe
- csr_rd_addr_o  out  12  CSR read/merge address; held for the whole transaction
- csr_rd_data_i  in  XLEN  CSR read data; registered by the file, valid the cycle after csr_rd_o
- csr_rd_illegal_rd_i  in  1  read illegal; valid with csr_rd_data_i
- csr_rd_illegal_wr_i  in  1  write illegal; valid with csr_rd_data_i
- csr_wr_o  out  1  CSR write strobe
- csr_wr_mode_o  out  2  equal to the latched op
- csr_wr_addr_o  out  12  latched address
- csr_wr_data_o  out  XLEN  latched src
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  writeback accepts response
- rsp_rd_o  out  5  latched rd
- rsp_data_o  out  XLEN  captured old CSR value
- rsp_wen_o  out  1  register-file write required
- rsp_illegal_o  out  1  raise illegal-instruction exception

## Operation
- States are IDLE, READ, CHECK, WRITE and RESP. Outputs are decoded from state and latched fields (Moore).
- A transition or capture occurs only on an edge where clk_en_i=1. Handshakes complete only when clk_en_i=1.
- IDLE: req_ready_o=1. When req_valid_i is high, latch op/addr/src/src_zero/rd and go to READ.
- READ: csr_rd_o=1. Go to CHECK.
- CHECK: capture csr_rd_data_i into rsp_data_o. Derive the following:
  - rd_need = (op≠01) | (rd≠0)
  - wr_need = (op=01) | ~src_zero
  - illegal = (op=00) | (rd_need & illegal_rd) | (wr_need & illegal_wr)
  - Next state is WRITE if wr_need & ~illegal, otherwise RESP.
- WRITE: csr_wr_o=1 for exactly one enabled cycle. Go to RESP.
- RESP: rsp_valid_o=1, rsp_illegal_o=illegal, rsp_wen_o = rd_need & (rd≠0) & ~illegal. On rsp_ready_i, go to IDLE.
- A read cycle is always issued, even for RW with rd=0, because it supplies the illegal flags. The read has no side effects in the CSR file.
- csr_rd_addr_o equals the latched address from READ through RESP, so the file's merge uses the correct CSR during WRITE.
- When rsp_illegal_o=1, no csr_wr_o is issued.

## Timing
- Reset: state IDLE. All latched fields are 0, so csr_rd_o, csr_wr_o, rsp_valid_o, rsp_wen_o and rsp_illegal_o are 0. req_ready_o is 1 from the first cycle after reset deasserts.
- Latency: accept at T, csr_rd_o at T+1, CHECK at T+2. With a write: csr_wr_o at T+3, rsp_valid_o from T+4. Without a write or when illegal: rsp_valid_o from T+3.
- rsp_* outputs are stable while rsp_valid_o=1 and rsp_ready_i=0.
- Throughput: the next request is accepted no earlier than the cycle after the response handshake.
- req_ready_o=0 in every state except IDLE.
- Reset asserted in any state forces IDLE on that edge. No csr_wr_o is emitted afterwards, and an in-flight response is dropped.
- clk_en_i=0 during WRITE extends csr_wr_o, and the CSR file sees exactly one enabled write.

## Test plan
- CSRRW, addr 0x340, src 0xDEADBEEF, rd=5, old value 0x00000000, flags clear -> csr_rd_o at T+1, csr_wr_o at T+3 with mode 01 and data 0xDEADBEEF, response at T+4 with rd=5, data 0x00000000, wen=1, illegal=0.
- CSRRS, addr 0xF14, src_zero=1, rd=7, read data 0x0 -> no csr_wr_o, response at T+3 with wen=1, illegal=0.
- CSRRW, addr 0xF11, rd=0, illegal_wr=1 -> no csr_wr_o, response with illegal=1, wen=0.
- op=00 -> illegal=1, no write. Separately, CSRRC with src=0x8, rd=0 -> csr_wr_o with mode 11, data 0x8, wen=0.
- Hold rsp_ready_i=0 for 5 cycles and drop clk_en_i for 2 cycles during WRITE -> outputs held stable, a single write occurs, and the next request is accepted only after the handshake.
- Assert reset_i during CHECK of a CSRRW -> the next cycle is IDLE with req_ready_o=1, and no csr_wr_o or rsp_valid_o ever appears for that request.
